rst_sequencer: RTL
==================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2: number of PLL/MMCM lock inputs, legal range 1-8.
REQ-002 SHALL have parameter NUM_DOMAINS, default 2: number of sequenced reset outputs, legal range 1-8.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: hclk cycles in HOLD before the first domain release, legal range 1-65535.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 4: hclk cycles between consecutive domain releases, legal range 1-255.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000: cycles the synchronised button must be stable to count as pressed or released, legal range 1-2^20.
REQ-006 SHALL have port hclk, input, 1 bit: clock; every flop uses its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port lock_i, input, NUM_LOCKS bits: asynchronous PLL lock flags.
REQ-009 SHALL have port btn_i, input, 1 bit: asynchronous pushbutton, active-high.
REQ-010 SHALL have port sw_req_i, input, 1 bit: synchronous single-cycle software reset request.
REQ-011 SHALL have port cause_clr_i, input, 1 bit: synchronous pulse that clears reset_cause_o.
REQ-012 SHALL have port rst_n_o, output, NUM_DOMAINS bits: registered active-low domain resets.
REQ-013 SHALL have port all_rel_o, output, 1 bit: high when every rst_n_o bit is high.
REQ-014 SHALL have port reset_cause_o, output, 4 bits: sticky cause flags, {sw, button, lock_loss, por}.

Function
REQ-015 SHALL pass each lock_i bit and btn_i through a 2-flop synchroniser before any use.
REQ-016 SHALL debounce the synchronised button with a counter that restarts on every change.
- Debounced state updates only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-017 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN.
REQ-018 ASSERT SHALL drive all rst_n_o bits low.
- Leaves for HOLD when all synchronised locks are high and the debounced button is low.
REQ-019 HOLD SHALL count HOLD_CYCLES cycles, then move to RELEASE.
- rst_n_o[0] is registered high on the HOLD->RELEASE edge: exactly HOLD_CYCLES cycles after HOLD entry.
REQ-020 RELEASE SHALL raise rst_n_o[k] exactly STAGGER_CYCLES cycles after rst_n_o[k-1], in ascending k.
- Goes to RUN in the same cycle the last bit rises.
- If NUM_DOMAINS=1, goes straight from HOLD to RUN.
REQ-021 An abort condition SHALL return the FSM to ASSERT from HOLD, RELEASE or RUN, with all rst_n_o low on the next edge.
- Abort conditions: any synchronised lock low, a debounced button press edge, or sw_req_i high.
- Abort clears the hold and stagger counters.
REQ-022 Latency SHALL be exactly 3 hclk edges from a lock_i bit falling to all rst_n_o low; from sw_req_i high it SHALL be 1 edge.
REQ-023 sw_req_i SHALL be ignored in ASSERT.
- Its cause bit is still set.
REQ-024 A held button SHALL keep the FSM in ASSERT until the debounced release.
REQ-025 reset_cause_o bits SHALL set on the cycle their abort condition is detected and stay set until cause_clr_i.
- If cause_clr_i coincides with a new cause, set wins for that bit and other bits clear.
REQ-026 Several simultaneous abort causes SHALL each set their own bit in the same cycle.
REQ-027 all_rel_o SHALL be a registered AND of rst_n_o, updated on the same edge as rst_n_o.
REQ-028 The hold counter SHALL be 16 bits and the stagger counter 8 bits.
- Neither counter wraps: each stops at terminal count until the state changes.

Reset
REQ-029 While RESET is high on a hclk edge, the block SHALL apply these values:
- FSM = ASSERT, rst_n_o = 0, all_rel_o = 0.
- reset_cause_o = 4'b0001 (por).
- Synchronisers, debounce state and all counters = 0.
REQ-030 RESET asserted mid-sequence SHALL override all other inputs on that edge.
- Sequencing then restarts from ASSERT.

Verification
(Bench parameters for all scenarios: NUM_LOCKS=2, NUM_DOMAINS=3, HOLD=16, STAGGER=4, DEBOUNCE=8.)
REQ-031 Scenario: locks high from reset release.
- Required: rst_n_o = 001 at HOLD entry+16, 011 at +20, 111 at +24.
- Required: all_rel_o rises at +24; cause = 0001.
REQ-032 Scenario: in RUN, lock_i[1] drops for 1 cycle.
- Required: rst_n_o = 000 exactly 3 edges later; cause = 0011.
- Required: the full sequence re-runs once the lock is high again.
REQ-033 Scenario: btn_i glitches high for 5 cycles.
- Required: no abort.
- Then btn_i held high for 20 cycles. Required: abort after 2+8 cycles; FSM stays in ASSERT until 10 cycles after release; cause bit 2 set.
REQ-034 Scenario: sw_req_i pulsed during RELEASE with rst_n_o = 011.
- Required: rst_n_o = 000 next edge; cause bit 3 set.
- Then cause_clr_i pulsed alone. Required: cause = 0000.
REQ-035 Scenario: RESET pulsed in RUN together with sw_req_i.
- Required: rst_n_o = 000, cause = 0001, FSM = ASSERT.
REQ-036 Scenario: sw_req_i and cause_clr_i in the same cycle, with cause = 0011.
- Required: cause = 1000.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: gathers PLL lock flags, a debounced pushbutton and a
// software request, then releases NUM_DOMAINS active-low resets in order
// after a hold period, with a fixed stagger between domains. Sticky cause
// flags record why the last reset sequence started.
module rst_sequencer #(
    parameter int NUM_LOCKS       = 2,
    parameter int NUM_DOMAINS     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                   hclk,
    input  logic                   RESET,
    input  logic [NUM_LOCKS-1:0]   lock_i,
    input  logic                   btn_i,
    input  logic                   sw_req_i,
    input  logic                   cause_clr_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   all_rel_o,
    output logic [3:0]             reset_cause_o
);

    // Debounce counter is wide enough for DEBOUNCE_CYCLES up to 2^20.
    localparam int DB_W = 21;
    localparam logic [DB_W-1:0]        DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]            HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]             STAG_LAST  = 8'(STAGGER_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] FIRST_DOM  = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic [NUM_LOCKS-1:0]   lock_meta;
    logic [NUM_LOCKS-1:0]   lock_sync;
    logic                   btn_meta;
    logic                   btn_sync;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt;
    logic                   db_diff;
    logic                   db_done;
    logic                   db_next;
    logic                   press;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            hold_cnt;
    logic [15:0]            hold_next;
    logic [7:0]             stag_cnt;
    logic [7:0]             stag_next;
    logic [NUM_DOMAINS-1:0] rst_next;
    logic [NUM_DOMAINS-1:0] raised;
    logic [3:0]             cause_next;
    logic [3:0]             cause_set;
    logic                   locks_ok;
    logic                   running;
    logic                   abort;

    // Two-flop synchronisers for the asynchronous lock flags and button.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            lock_meta <= '0;
            lock_sync <= '0;
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            lock_meta <= lock_i;
            lock_sync <= lock_meta;
            btn_meta  <= btn_i;
            btn_sync  <= btn_meta;
        end
    end

    // The counter tracks consecutive samples that disagree with the debounced
    // state; any agreeing sample restarts it, so only a steady level flips it.
    assign db_diff = (btn_sync != btn_db);
    assign db_done = db_diff && (db_cnt == DB_LAST);
    assign db_next = db_done ? btn_sync : btn_db;
    assign press   = db_done && btn_sync;

    // Debounce state and run-length counter.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (!db_diff) begin
            db_cnt <= '0;
        end else if (db_done) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign locks_ok = &lock_sync;
    assign running  = (state != ASSERT);
    assign abort    = !locks_ok || press || sw_req_i;
    // Next release pattern: one more domain raised, always in ascending order.
    assign raised   = (rst_n_o << 1) | FIRST_DOM;

    // Next-state, counter and reset-output decode for the sequencer FSM.
    always_comb begin
        state_next = state;
        hold_next  = 16'd0;
        stag_next  = 8'd0;
        rst_next   = rst_n_o;
        unique case (state)
            ASSERT: begin
                rst_next = '0;
                // Using the upcoming debounce value keeps a fresh press from
                // slipping through and lets a release start HOLD immediately.
                if (locks_ok && !db_next) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next = ASSERT;
                    rst_next   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    rst_next   = FIRST_DOM;
                    state_next = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                end else begin
                    hold_next = hold_cnt + 16'd1;
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_next = ASSERT;
                    rst_next   = '0;
                end else if (stag_cnt == STAG_LAST) begin
                    rst_next = raised;
                    if (raised[NUM_DOMAINS-1]) begin
                        state_next = RUN;
                    end
                end else begin
                    stag_next = stag_cnt + 8'd1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = ASSERT;
                    rst_next   = '0;
                end
            end
        endcase
    end

    // Cause flags: lock loss and button press only count once sequencing has
    // started; a software request is always recorded. Set beats clear.
    always_comb begin
        cause_set  = {sw_req_i, press && running, !locks_ok && running, 1'b0};
        cause_next = cause_set | (cause_clr_i ? 4'b0000 : reset_cause_o);
    end

    // State, counters and registered outputs.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            state         <= ASSERT;
            hold_cnt      <= 16'd0;
            stag_cnt      <= 8'd0;
            rst_n_o       <= '0;
            all_rel_o     <= 1'b0;
            reset_cause_o <= 4'b0001;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_next;
            stag_cnt      <= stag_next;
            rst_n_o       <= rst_next;
            all_rel_o     <= &rst_next;
            reset_cause_o <= cause_next;
        end
    end

endmodule
